// File: rtl/cas_arb_pkg.sv
// Shared types and helpers for the CAS download / tape playback DDRAM arbiter.
// Optional read cache is enabled with the CAS_ARB_RDCACHE_EN macro.
package cas_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_ISSUE = 2'd1,
        RD_ISSUE = 2'd2,
        RD_WAIT  = 2'd3
    } state_t;

    // DDRAM word address (64-bit units) of byte 0 of the CAS buffer
    localparam logic [28:0] CAS_BASE_ADDR = 29'h0300_0000;
    // Byte address width of both client ports
    localparam int          CAS_ADDR_W    = 27;

    // One-hot byte enable for a byte lane within a 64-bit word
    function automatic logic [7:0] lane_be(input logic [2:0] sel);
        return 8'b1 << sel;
    endfunction

    // Extract byte lane 'sel' from a 64-bit word
    function automatic logic [7:0] lane_byte(input logic [63:0] word, input logic [2:0] sel);
        return word[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/cas_rd_line.sv
// Single-line read cache for the CAS arbiter: one 64-bit word, its word tag
// and a valid bit. Only instantiated when CAS_ARB_RDCACHE_EN is defined.
module cas_rd_line
    import cas_arb_pkg::*;
#(
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic [2:0]       lookup_sel,
    output logic             hit,
    output logic [7:0]       hit_byte,
    input  logic             fill,
    input  logic [63:0]      fill_word,
    input  logic             inval,
    input  logic [TAG_W-1:0] inval_tag
);

    logic             line_valid;
    logic [TAG_W-1:0] line_tag;
    logic [63:0]      line_word;

    assign hit      = line_valid && (line_tag == lookup_tag);
    assign hit_byte = lane_byte(line_word, lookup_sel);

    // Line update: a fill replaces the whole line (new tag), otherwise a write
    // to the cached word drops it so the next read goes back to DDRAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_valid <= 1'b0;
            line_tag   <= '0;
            line_word  <= '0;
        end else if (fill) begin
            line_valid <= 1'b1;
            line_tag   <= lookup_tag;
            line_word  <= fill_word;
        end else if (inval && (inval_tag == line_tag)) begin
            line_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cas_ddram_arb.sv
// DDR3 byte-buffer arbiter between the OSD CAS download (write port) and tape
// playback (read port). Each byte request becomes one 64-bit Avalon access
// (burst of 1, single byte enable) relative to BASE_ADDR.
// Optional one-line read cache: define CAS_ARB_RDCACHE_EN.
module cas_ddram_arb
    import cas_arb_pkg::*;
#(
    parameter logic [28:0] BASE_ADDR = CAS_BASE_ADDR,
    parameter int          ADDR_W    = CAS_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              wr,
    output logic              wr_wait,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd,
    output logic [7:0]        rd_dout,
    output logic              rd_ready,
    input  logic              DDRAM_BUSY,
    input  logic [63:0]       DDRAM_DOUT,
    input  logic              DDRAM_DOUT_READY,
    output logic [28:0]       DDRAM_ADDR,
    output logic [7:0]        DDRAM_BURSTCNT,
    output logic [63:0]       DDRAM_DIN,
    output logic [7:0]        DDRAM_BE,
    output logic              DDRAM_RD,
    output logic              DDRAM_WE
);

    state_t            state;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic [ADDR_W-1:0] rd_addr_q;

    // A strobe is only accepted while its port is free; wr_wait / rd_ready
    // double as the pending flags of the two request registers.
    logic              wr_take;
    logic              rd_take;
    logic              wr_go;
    logic [ADDR_W-1:0] wr_addr_cur;
    logic [7:0]        wr_data_cur;
    logic              rd_hit;
    logic [7:0]        hit_byte;

    assign wr_take     = wr & ~wr_wait;
    assign rd_take     = rd & rd_ready;
    // A fresh write strobe seen in IDLE is issued on the same edge it is
    // captured, giving the two-cycle minimum write latency.
    assign wr_go       = wr_wait | wr;
    assign wr_addr_cur = wr_wait ? wr_addr_q : wr_addr;
    assign wr_data_cur = wr_wait ? wr_data_q : wr_data;

    assign DDRAM_BURSTCNT = 8'd1;

    function automatic logic [28:0] word_addr(input logic [ADDR_W-1:0] a);
        return BASE_ADDR + 29'(a[ADDR_W-1:3]);
    endfunction

`ifdef CAS_ARB_RDCACHE_EN
    localparam int TAG_W = ADDR_W - 3;

    logic             line_fill;
    logic             wr_same_word;

    // Do not fill the line with a word that a queued or just-captured write
    // is about to change; the fetched data would already be stale.
    assign wr_same_word = (wr_take && (wr_addr[ADDR_W-1:3] == rd_addr_q[ADDR_W-1:3])) ||
                          (wr_wait && (wr_addr_q[ADDR_W-1:3] == rd_addr_q[ADDR_W-1:3]));
    assign line_fill    = (state == RD_WAIT) && DDRAM_DOUT_READY && !wr_same_word;

    cas_rd_line #(
        .TAG_W (TAG_W)
    ) u_rd_line (
        .clk        (clk),
        .reset      (reset),
        .lookup_tag (rd_addr_q[ADDR_W-1:3]),
        .lookup_sel (rd_addr_q[2:0]),
        .hit        (rd_hit),
        .hit_byte   (hit_byte),
        .fill       (line_fill),
        .fill_word  (DDRAM_DOUT),
        .inval      (wr_take),
        .inval_tag  (wr_addr[ADDR_W-1:3])
    );
`else
    assign rd_hit   = 1'b0;
    assign hit_byte = 8'h00;
`endif

    // Request capture plus the access FSM; all DDRAM outputs are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_wait    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_ready   <= 1'b1;
            rd_addr_q  <= '0;
            rd_dout    <= '0;
            DDRAM_ADDR <= BASE_ADDR;
            DDRAM_DIN  <= '0;
            DDRAM_BE   <= '0;
            DDRAM_RD   <= 1'b0;
            DDRAM_WE   <= 1'b0;
        end else begin
            if (wr_take) begin
                wr_wait   <= 1'b1;
                wr_addr_q <= wr_addr;
                wr_data_q <= wr_data;
            end
            if (rd_take) begin
                rd_ready  <= 1'b0;
                rd_addr_q <= rd_addr;
            end

            case (state)
                IDLE: begin
                    if (wr_go) begin
                        state      <= WR_ISSUE;
                        DDRAM_WE   <= 1'b1;
                        DDRAM_ADDR <= word_addr(wr_addr_cur);
                        DDRAM_BE   <= lane_be(wr_addr_cur[2:0]);
                        DDRAM_DIN  <= {8{wr_data_cur}};
                    end else if (!rd_ready) begin
                        if (rd_hit) begin
                            rd_dout  <= hit_byte;
                            rd_ready <= 1'b1;
                        end else begin
                            state      <= RD_ISSUE;
                            DDRAM_RD   <= 1'b1;
                            DDRAM_ADDR <= word_addr(rd_addr_q);
                            DDRAM_BE   <= lane_be(rd_addr_q[2:0]);
                        end
                    end
                end
                WR_ISSUE: begin
                    if (!DDRAM_BUSY) begin
                        state    <= IDLE;
                        DDRAM_WE <= 1'b0;
                        wr_wait  <= 1'b0;
                    end
                end
                RD_ISSUE: begin
                    if (!DDRAM_BUSY) begin
                        state    <= RD_WAIT;
                        DDRAM_RD <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (DDRAM_DOUT_READY) begin
                        state    <= IDLE;
                        rd_dout  <= lane_byte(DDRAM_DOUT, rd_addr_q[2:0]);
                        rd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Client protocol: no new strobe while the same port is still busy.
    wr_while_busy: assert property (@(posedge clk) disable iff (reset) !(wr && wr_wait));
    rd_while_busy: assert property (@(posedge clk) disable iff (reset) !(rd && !rd_ready));

endmodule

// File: tb/tb_cas_ddram_arb.sv
// Bench for cas_ddram_arb: Avalon slave model with configurable BUSY and read
// latency, byte-level reference memory, directed and randomized scenarios.
`timescale 1ns/1ps
module tb_cas_ddram_arb;

    localparam logic [28:0] BASE = 29'h0300_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [26:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr = 1'b0;
    logic        wr_wait;
    logic [26:0] rd_addr = '0;
    logic        rd = 1'b0;
    logic [7:0]  rd_dout;
    logic        rd_ready;
    logic        busy;
    logic [63:0] dout_r = '0;
    logic        dout_ready_r = 1'b0;
    logic [28:0] ddr_addr;
    logic [7:0]  ddr_burst;
    logic [63:0] ddr_din;
    logic [7:0]  ddr_be;
    logic        ddr_rd;
    logic        ddr_we;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    cas_ddram_arb dut (
        .clk              (clk),
        .reset            (rst),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr               (wr),
        .wr_wait          (wr_wait),
        .rd_addr          (rd_addr),
        .rd               (rd),
        .rd_dout          (rd_dout),
        .rd_ready         (rd_ready),
        .DDRAM_BUSY       (busy),
        .DDRAM_DOUT       (dout_r),
        .DDRAM_DOUT_READY (dout_ready_r),
        .DDRAM_ADDR       (ddr_addr),
        .DDRAM_BURSTCNT   (ddr_burst),
        .DDRAM_DIN        (ddr_din),
        .DDRAM_BE         (ddr_be),
        .DDRAM_RD         (ddr_rd),
        .DDRAM_WE         (ddr_we)
    );

    // ---------------- reference byte memory ----------------
    logic [7:0]  ref_mem [int];
    logic [63:0] mem [int];

    function automatic logic [7:0] init_byte(int a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ref_byte(int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [63:0] get_word(int w);
        logic [63:0] v;
        if (mem.exists(w)) return mem[w];
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = init_byte(w * 8 + i);
        return v;
    endfunction

    // ---------------- Avalon slave model ----------------
    typedef struct {
        longint      due;
        logic [63:0] word;
    } rsp_t;

    int     busy_cfg = 0;
    int     lat_cfg = 1;
    int     run = 0;
    longint cyc = 0;
    rsp_t   rq[$];
    int     op_log[$];
    int     we_acc = 0;
    int     rd_acc = 0;

    assign busy = (run < busy_cfg);

    always @(posedge clk) begin : slave
        logic [63:0] word;
        int w;
        cyc <= cyc + 1;
        if ((ddr_we || ddr_rd) && busy) run <= run + 1;
        else run <= 0;
        if (ddr_we && !busy) begin
            w = int'(ddr_addr - BASE);
            word = get_word(w);
            for (int i = 0; i < 8; i++)
                if (ddr_be[i]) word[i*8 +: 8] = ddr_din[i*8 +: 8];
            mem[w] = word;
            we_acc++;
            op_log.push_back(1);
        end
        if (ddr_rd && !busy) begin
            w = int'(ddr_addr - BASE);
            rq.push_back('{cyc + longint'(lat_cfg), get_word(w)});
            rd_acc++;
            op_log.push_back(2);
        end
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            dout_r       <= rq[0].word;
            dout_ready_r <= 1'b1;
            void'(rq.pop_front());
        end else begin
            dout_ready_r <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd_ready();
        int n = 0;
        while (!rd_ready && n < 500) begin tick(); n++; end
        if (!rd_ready) begin
            compared++; mismatched++;
            $display("FAIL rd_ready_timeout: rd_ready=%0b required 1", rd_ready);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((wr_wait || !rd_ready) && n < 500) begin tick(); n++; end
        if (wr_wait || !rd_ready) begin
            compared++; mismatched++;
            $display("FAIL idle_timeout: wr_wait=%0b rd_ready=%0b required 0/1", wr_wait, rd_ready);
        end
    endtask

    task automatic do_write(input int a, input logic [7:0] d);
        int n = 0;
        while (wr_wait && n < 500) begin tick(); n++; end
        if (wr_wait) begin
            compared++; mismatched++;
            $display("FAIL wr_wait_timeout: wr_wait=%0b required 0", wr_wait);
        end
        wr_addr = 27'(a); wr_data = d; wr = 1'b1;
        tick();
        wr = 1'b0;
        ref_mem[a] = d;
        $display("wr  addr=%06h data=%02h", a, d);
    endtask

    task automatic do_read(input int a, output logic [7:0] v, output int cycles);
        wait_rd_ready();
        rd_addr = 27'(a); rd = 1'b1;
        tick();
        rd = 1'b0;
        cycles = 1;
        while (!rd_ready && cycles < 500) begin tick(); cycles++; end
        if (!rd_ready) begin
            compared++; mismatched++;
            $display("FAIL rd_timeout: rd_ready=%0b required 1", rd_ready);
        end
        v = rd_dout;
        $display("rd  addr=%06h data=%02h cycles=%0d", a, v, cycles);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        compared += 9;
        if (wr_wait !== 1'b0)  begin mismatched++; $display("FAIL reset_wr_wait: got %0b required 0", wr_wait); end
        if (rd_ready !== 1'b1) begin mismatched++; $display("FAIL reset_rd_ready: got %0b required 1", rd_ready); end
        if (rd_dout !== 8'h00) begin mismatched++; $display("FAIL reset_rd_dout: got %02h required 00", rd_dout); end
        if (ddr_rd !== 1'b0)   begin mismatched++; $display("FAIL reset_rd: got %0b required 0", ddr_rd); end
        if (ddr_we !== 1'b0)   begin mismatched++; $display("FAIL reset_we: got %0b required 0", ddr_we); end
        if (ddr_be !== 8'h00)  begin mismatched++; $display("FAIL reset_be: got %02h required 00", ddr_be); end
        if (ddr_addr !== BASE) begin mismatched++; $display("FAIL reset_addr: got %h required %h", ddr_addr, BASE); end
        if (ddr_din !== 64'h0) begin mismatched++; $display("FAIL reset_din: got %h required 0", ddr_din); end
        if (ddr_burst !== 8'd1) begin mismatched++; $display("FAIL reset_burstcnt: got %0d required 1", ddr_burst); end
        rst = 1'b0;
        tick();
        $display("reset released");
    endtask

    task automatic test_write_basic();
        logic [7:0] v;
        int c;
        int we0;
        wait_idle();
        busy_cfg = 0;
        we0 = we_acc;
        wr_addr = 27'h00000A; wr_data = 8'h5C; wr = 1'b1;
        tick();
        wr = 1'b0;
        ref_mem[32'h0A] = 8'h5C;
        compared += 5;
        if (ddr_we !== 1'b1) begin mismatched++; $display("FAIL wr_we_issue: got %0b required 1", ddr_we); end
        if (ddr_addr !== BASE + 29'd1) begin mismatched++; $display("FAIL wr_addr: got %h required %h", ddr_addr, BASE + 29'd1); end
        if (ddr_be !== 8'h04) begin mismatched++; $display("FAIL wr_be: got %02h required 04", ddr_be); end
        if (ddr_din !== {8{8'h5C}}) begin mismatched++; $display("FAIL wr_din: got %h required %h", ddr_din, {8{8'h5C}}); end
        if (wr_wait !== 1'b1) begin mismatched++; $display("FAIL wr_wait_high: got %0b required 1", wr_wait); end
        tick();
        compared += 3;
        if (ddr_we !== 1'b0) begin mismatched++; $display("FAIL wr_we_drop: got %0b required 0", ddr_we); end
        if (wr_wait !== 1'b0) begin mismatched++; $display("FAIL wr_wait_low: got %0b required 0", wr_wait); end
        if (we_acc - we0 !== 1) begin mismatched++; $display("FAIL wr_we_count: got %0d required 1", we_acc - we0); end
        $display("wr  addr=00000a data=5c (basic)");
        do_read(32'h0A, v, c);
        compared++;
        if (v !== 8'h5C) begin mismatched++; $display("FAIL wr_readback: got %02h required 5c", v); end
    endtask

    task automatic test_write_busy();
        int a, we_cycles, n, unstable, wait_low;
        logic [7:0] d;
        wait_idle();
        a = $urandom_range(0, 255);
        d = 8'($urandom);
        busy_cfg = 5;
        wr_addr = 27'(a); wr_data = d; wr = 1'b1;
        tick();
        wr = 1'b0;
        ref_mem[a] = d;
        we_cycles = 0; n = 0; unstable = 0; wait_low = 0;
        while (ddr_we && n < 50) begin
            we_cycles++; n++;
            if (ddr_addr !== BASE + 29'(a / 8) || ddr_be !== 8'(1 << (a % 8)) || ddr_din !== {8{d}}) unstable++;
            if (wr_wait !== 1'b1) wait_low++;
            tick();
        end
        busy_cfg = 0;
        compared += 4;
        if (we_cycles !== 6) begin mismatched++; $display("FAIL busy_we_cycles: got %0d required 6", we_cycles); end
        if (unstable !== 0) begin mismatched++; $display("FAIL busy_stable: got %0d changed cycles required 0", unstable); end
        if (wait_low !== 0) begin mismatched++; $display("FAIL busy_wr_wait: got %0d low cycles required 0", wait_low); end
        if (wr_wait !== 1'b0) begin mismatched++; $display("FAIL busy_wr_wait_end: got %0b required 0", wr_wait); end
        $display("wr  addr=%06h data=%02h busy=5 we_cycles=%0d", a, d, we_cycles);
    endtask

    task automatic test_read_basic();
        int n, rd0, early;
        logic [28:0] seen_addr;
        wait_idle();
        mem[2] = 64'h8877665544332211;
        for (int i = 0; i < 8; i++) ref_mem[16 + i] = 8'(64'h8877665544332211 >> (8 * i));
        lat_cfg = 10; busy_cfg = 0;
        rd0 = rd_acc;
        seen_addr = '0;
        rd_addr = 27'h000013; rd = 1'b1;
        tick();
        rd = 1'b0;
        n = 0; early = 0;
        while (!dout_ready_r && n < 100) begin
            if (ddr_rd) seen_addr = ddr_addr;
            if (rd_ready) early++;
            tick(); n++;
        end
        compared += 4;
        if (early !== 0 || rd_ready !== 1'b0) begin mismatched++; $display("FAIL rd_ready_early: got %0d early cycles required 0", early); end
        if (seen_addr !== BASE + 29'd2) begin mismatched++; $display("FAIL rd_addr: got %h required %h", seen_addr, BASE + 29'd2); end
        if (rd_acc - rd0 !== 1) begin mismatched++; $display("FAIL rd_count: got %0d required 1", rd_acc - rd0); end
        if (!dout_ready_r) begin mismatched++; $display("FAIL rd_dout_ready_seen: got 0 required 1"); end
        tick();
        compared += 2;
        if (rd_ready !== 1'b1) begin mismatched++; $display("FAIL rd_ready_after: got %0b required 1", rd_ready); end
        if (rd_dout !== 8'h44) begin mismatched++; $display("FAIL rd_dout: got %02h required 44", rd_dout); end
        $display("rd  addr=000013 data=%02h lat=10", rd_dout);
        lat_cfg = 1;
    endtask

    task automatic test_simultaneous();
        logic [7:0] v, d;
        int c, rd0;
        wait_idle();
        lat_cfg = $urandom_range(1, 4);
        do_read(32'h11, v, c);
        compared++;
        if (v !== ref_byte(32'h11)) begin mismatched++; $display("FAIL sim_warm: got %02h required %02h", v, ref_byte(32'h11)); end
        d = 8'($urandom);
        op_log.delete();
        rd0 = rd_acc;
        wr_addr = 27'h10; wr_data = d; rd_addr = 27'h11; wr = 1'b1; rd = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b0;
        ref_mem[32'h10] = d;
        wait_rd_ready();
        compared += 3;
        if (op_log.size() !== 2 || op_log[0] !== 1 || op_log[1] !== 2) begin
            mismatched++; $display("FAIL sim_order: got %0d ops first=%0d required WE then RD", op_log.size(), (op_log.size() > 0) ? op_log[0] : 0);
        end
        if (rd_acc - rd0 !== 1) begin mismatched++; $display("FAIL sim_rd_miss: got %0d reads required 1", rd_acc - rd0); end
        if (rd_dout !== ref_byte(32'h11)) begin mismatched++; $display("FAIL sim_data: got %02h required %02h", rd_dout, ref_byte(32'h11)); end
        $display("wr+rd wr=000010/%02h rd=000011 data=%02h", d, rd_dout);
        do_read(32'h10, v, c);
        compared++;
        if (v !== d) begin mismatched++; $display("FAIL sim_readback: got %02h required %02h", v, d); end
    endtask

    task automatic test_cache();
        logic [7:0] v, d;
        int c, rd0, exp_rds;
        wait_idle();
        lat_cfg = 3;
        rd0 = rd_acc;
        do_read(32'h20, v, c);
        compared++;
        if (v !== ref_byte(32'h20)) begin mismatched++; $display("FAIL cache_first: got %02h required %02h", v, ref_byte(32'h20)); end
        do_read(32'h27, v, c);
        compared++;
        if (v !== ref_byte(32'h27)) begin mismatched++; $display("FAIL cache_second: got %02h required %02h", v, ref_byte(32'h27)); end
`ifdef CAS_ARB_RDCACHE_EN
        exp_rds = 1;
        compared++;
        if (c !== 2) begin mismatched++; $display("FAIL cache_hit_latency: got %0d required 2", c); end
`else
        exp_rds = 2;
`endif
        compared++;
        if (rd_acc - rd0 !== exp_rds) begin mismatched++; $display("FAIL cache_rd_count: got %0d required %0d", rd_acc - rd0, exp_rds); end
        d = ~ref_byte(32'h23);
        rd0 = rd_acc;
        do_write(32'h23, d);
        do_read(32'h23, v, c);
        compared += 2;
        if (v !== d) begin mismatched++; $display("FAIL cache_inval_data: got %02h required %02h", v, d); end
        if (rd_acc - rd0 !== 1) begin mismatched++; $display("FAIL cache_inval_miss: got %0d reads required 1", rd_acc - rd0); end
    endtask

    task automatic test_random();
        logic [7:0] v, d;
        int a, b, c, kind;
        for (int k = 0; k < 60; k++) begin
            wait_idle();
            busy_cfg = $urandom_range(0, 3);
            lat_cfg = $urandom_range(1, 6);
            kind = $urandom_range(0, 9);
            a = 'h40 + $urandom_range(0, 63);
            b = 'h40 + $urandom_range(0, 63);
            d = 8'($urandom);
            if (kind < 3) begin
                do_write(a, d);
            end else if (kind < 5) begin
                do_write(a, d);
                do_read(b, v, c);
                compared++;
                if (v !== ref_byte(b)) begin mismatched++; $display("FAIL rand_wr_rd %06h: got %02h required %02h", b, v, ref_byte(b)); end
            end else if (kind < 8) begin
                do_read(a, v, c);
                compared++;
                if (v !== ref_byte(a)) begin mismatched++; $display("FAIL rand_rd %06h: got %02h required %02h", a, v, ref_byte(a)); end
            end else begin
                wr_addr = 27'(a); wr_data = d; rd_addr = 27'(b); wr = 1'b1; rd = 1'b1;
                tick();
                wr = 1'b0; rd = 1'b0;
                ref_mem[a] = d;
                wait_rd_ready();
                compared++;
                if (rd_dout !== ref_byte(b)) begin mismatched++; $display("FAIL rand_sim %06h: got %02h required %02h", b, rd_dout, ref_byte(b)); end
                $display("wr+rd wr=%06h/%02h rd=%06h data=%02h", a, d, b, rd_dout);
            end
        end
        busy_cfg = 0;
        lat_cfg = 1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        int n, bad_ready, bad_dout, c;
        // reset while RD is held off by BUSY
        wait_idle();
        busy_cfg = 1000;
        rd_addr = 27'h30; rd = 1'b1;
        tick();
        rd = 1'b0;
        n = 0;
        while (!ddr_rd && n < 20) begin tick(); n++; end
        #2 rst = 1'b1;
        #1;
        compared += 2;
        if (ddr_rd !== 1'b0) begin mismatched++; $display("FAIL rst_issue_rd: got %0b required 0", ddr_rd); end
        if (rd_ready !== 1'b1) begin mismatched++; $display("FAIL rst_issue_ready: got %0b required 1", rd_ready); end
        repeat (4) tick();
        busy_cfg = 0;
        rst = 1'b0;
        tick();
        // reset while waiting for read data; DOUT_READY arrives later
        lat_cfg = 20;
        rd_addr = 27'h30; rd = 1'b1;
        tick();
        rd = 1'b0;
        n = 0;
        while (!ddr_rd && n < 20) begin tick(); n++; end
        while (ddr_rd && n < 40) begin tick(); n++; end
        tick();
        #2 rst = 1'b1;
        #1;
        compared += 4;
        if (ddr_rd !== 1'b0) begin mismatched++; $display("FAIL rst_wait_rd: got %0b required 0", ddr_rd); end
        if (ddr_we !== 1'b0) begin mismatched++; $display("FAIL rst_wait_we: got %0b required 0", ddr_we); end
        if (rd_ready !== 1'b1) begin mismatched++; $display("FAIL rst_wait_ready: got %0b required 1", rd_ready); end
        if (rd_dout !== 8'h00) begin mismatched++; $display("FAIL rst_wait_dout: got %02h required 00", rd_dout); end
        repeat (4) tick();
        rst = 1'b0;
        bad_ready = 0; bad_dout = 0;
        repeat (30) begin
            tick();
            if (rd_ready !== 1'b1) bad_ready++;
            if (rd_dout !== 8'h00 || ddr_rd !== 1'b0) bad_dout++;
        end
        compared += 2;
        if (bad_ready !== 0) begin mismatched++; $display("FAIL late_ready: got %0d bad cycles required 0", bad_ready); end
        if (bad_dout !== 0) begin mismatched++; $display("FAIL late_dout: got %0d bad cycles required 0", bad_dout); end
        $display("reset during read, late DOUT_READY ignored");
        lat_cfg = 2;
        do_read(32'h30, v, c);
        compared++;
        if (v !== ref_byte(32'h30)) begin mismatched++; $display("FAIL rst_after_read: got %02h required %02h", v, ref_byte(32'h30)); end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_busy();
        test_read_basic();
        test_simultaneous();
        test_cache();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
